// File: rtl/regfile_write_arbiter_pkg.sv
// Shared writeback types for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  typedef logic [31:0] Word;
  typedef logic [4:0]  RegAddress;

  typedef struct packed {
    RegAddress addr;
    Word       data;
  } WbReq;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } WbSource;

  localparam int NUM_SRC  = 2;
  localparam int NUM_REGS = 32;

  // One-hot decode of a register address into a per-register mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input RegAddress a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_slot.sv
// One-entry writeback holding slot. Writes to r0 are accepted and dropped.
// o_old marks an entry that has already lost arbitration once, so it is the
// older of the two when both slots target the same register.
module regfile_write_arbiter_wb_hold_slot
  import regfile_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_valid,
  input  WbReq i_req,
  input  logic i_grant,
  input  logic i_other_held,
  output logic o_ready,
  output logic o_held,
  output logic o_old,
  output WbReq o_req
);

  logic r_held;
  logic r_old;
  WbReq r_req;
  logic w_take;

  assign o_ready = ~r_held | i_grant;
  assign w_take  = i_valid & o_ready & (i_req.addr != '0);
  assign o_held  = r_held;
  assign o_old   = r_old;
  assign o_req   = r_req;

  // Capture on handshake, free on grant; age only while competing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_held <= 1'b0;
      r_old  <= 1'b0;
      r_req  <= '0;
    end else begin
      if (w_take) begin
        r_held <= 1'b1;
        r_req  <= i_req;
      end else if (i_grant) begin
        r_held <= 1'b0;
      end
      r_old <= r_held & ~i_grant & i_other_held;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: ALU writeback (source 0) and LSU/multi-cycle
// return (source 1) share one registered write port. Exports a pending-write
// mask for the hazard unit.
// Optional: WB_ARB_ROUND_ROBIN_EN selects round-robin for contested
// different-address grants; otherwise source 1 always wins them.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  RegAddress           req0_addr,
  input  Word                 req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  RegAddress           req1_addr,
  input  Word                 req1_data,
  output logic                rf_write_enable,
  output RegAddress           rf_addr_write,
  output Word                 rf_in,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_SRC-1:0] w_valid, w_ready, w_held, w_old, w_grant;
  WbReq [NUM_SRC-1:0] w_in, w_slot;
  logic               w_same, w_win1;
  logic               r_we;
  RegAddress          r_waddr;
  Word                r_wdata;
  logic [NUM_REGS-1:0] w_pending;

  assign w_valid = {req1_valid, req0_valid};
  assign w_in[0] = '{addr: req0_addr, data: req0_data};
  assign w_in[1] = '{addr: req1_addr, data: req1_data};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    regfile_write_arbiter_wb_hold_slot u_slot (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_valid      (w_valid[g]),
      .i_req        (w_in[g]),
      .i_grant      (w_grant[g]),
      .i_other_held (w_held[1-g]),
      .o_ready      (w_ready[g]),
      .o_held       (w_held[g]),
      .o_old        (w_old[g]),
      .o_req        (w_slot[g])
    );
  end

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];

`ifdef WB_ARB_ROUND_ROBIN_EN
  WbSource r_rr;
`endif

  // Grant: lone slot wins; same address -> older (tie goes to slot 1);
  // different address -> round-robin or fixed slot-1 priority.
  always_comb begin
    w_same = (w_slot[0].addr == w_slot[1].addr);
    w_win1 = 1'b1;
    if (w_same) w_win1 = w_old[1] | ~w_old[0];
`ifdef WB_ARB_ROUND_ROBIN_EN
    else        w_win1 = (r_rr == WB_LSU);
`endif
    w_grant[1] = w_held[1] & (~w_held[0] | w_win1);
    w_grant[0] = w_held[0] & ~w_grant[1];
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Point at the loser after every contested different-address grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      r_rr <= WB_ALU;
    else if (&w_held && !w_same)       r_rr <= w_grant[1] ? WB_ALU : WB_LSU;
  end
`endif

  // Output stage: register the granted write straight into the RF port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= |w_grant;
      if (|w_grant) begin
        r_waddr <= w_grant[1] ? w_slot[1].addr : w_slot[0].addr;
        r_wdata <= w_grant[1] ? w_slot[1].data : w_slot[0].data;
      end
    end
  end

  assign rf_write_enable = r_we;
  assign rf_addr_write   = r_waddr;
  assign rf_in           = r_wdata;

  // Pending mask: held slots plus the staged write; r0 never pending.
  always_comb begin
    w_pending = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (w_held[s]) w_pending |= reg_onehot(w_slot[s].addr);
    if (r_we) w_pending |= reg_onehot(r_waddr);
    w_pending[0] = 1'b0;
  end

  assign pending = w_pending;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback sources: source 0 is the single-cycle ALU writeback and source 1 is the long-latency load/multi-cycle unit return. Each source gets a one-entry holding slot with a valid/ready handshake, and the arbiter drives registered write-enable, address and data directly into the register file. It also exports a pending-write mask that the hazard unit uses to stall readers of registers whose writes are still in flight.

## Interface
Parameters:
- none; widths come from the shared `Word` (32-bit) and `RegAddress` (5-bit) types.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  source has a write to offer.
- `req0_ready` / `req1_ready`  out  1  arbiter accepts the offer this cycle.
- `req0_addr` / `req1_addr`  in  `RegAddress`  destination register.
- `req0_data` / `req1_data`  in  `Word`  write value.
- `rf_write_enable`  out  1  drives the register file's write enable.
- `rf_addr_write`  out  `RegAddress`  drives the register file's write address.
- `rf_in`  out  `Word`  drives the register file's write data.
- `pending`  out  32  bit a is set while a write to register a is held or staged.

## Operation
- Handshake: a transfer occurs at an edge where `reqN_valid & reqN_ready`. Once valid is high, addr and data are held stable until the transfer.
- `reqN_ready = !heldN | grantN`. A full slot that is being granted can accept a new request in the same cycle.
- A write to address 0 is accepted and then discarded. It never occupies a slot, never sets `pending`, and never asserts `rf_write_enable`.
- Per-slot state: `held`, addr, data, and an `old` bit. `old` is set after the slot survives one edge while the other slot is also held.
- Grant, combinational over the held slots:
  - Only one slot held: grant it.
  - Both held with equal addr: grant the older slot. If both were captured at the same edge, grant slot 1 (its instruction is older in program order).
  - Both held with different addr: round-robin. The pointer flips to the other source after each contested grant.
- Exactly one grant per cycle at most. The granted slot's addr/data are registered into the `rf_*` outputs. `rf_write_enable` is high for exactly one cycle per granted write.
- `pending`: the OR of the one-hot decodes of each held slot addr and of `rf_addr_write` while `rf_write_enable` is high. Bit 0 is always 0. It is combinational from registered state.

## Timing
- Reset (asynchronous assert, synchronous release): both slots empty, `old` bits cleared, round-robin pointer favors source 0.
- Outputs after reset: `rf_write_enable`=0, `rf_addr_write`=0, `rf_in`=0, `pending`=0, both readies=1.
- Reset mid-operation drops all held and staged writes. The register file is not written for them.
- Uncontested latency: accept at edge E0, grant during the following cycle, `rf_*` loaded at E1, register file written at E2.
- Contested: the losing slot waits one cycle per grant ahead of it. Its ready stays low, so the source stalls.
- Throughput: one register-file write per cycle sustained.
- `pending` bits clear in the cycle after the register-file write edge.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN` defined: contested different-address grants alternate between sources as above.
- Not defined: fixed priority, with slot 1 always winning. The round-robin pointer is not built.
- The equal-address age rule applies in both builds.

## Structure
- Shared package (`types.sv`) additions:
  - struct `WbReq` {`RegAddress addr; Word data;`}
  - enum `WbSource` {`WB_ALU`, `WB_LSU`}
- Sub-module `wb_hold_slot`: one-entry holding register with valid/ready, `held`, `old` and an asynchronous active-low reset. It is instantiated twice.
- The arbiter top level contains the grant logic, the output stage and the `pending` decode.

## Test plan
- Reset: hold `reset_n`=0 with both valids high → both readies=1, `rf_write_enable`=0, `pending`=0.
- Single write: req0 writes r5=0x11 at E0 → `pending[5]`=1 from E0, `rf_write_enable` high in the cycle after E1 with addr 5 / data 0x11, register file r5=0x11 after E2.
- Contention: both valid at the same edge to r3/r7, with `WB_ARB_ROUND_ROBIN_EN` → source 0 granted first and `req1_ready`=0 for one cycle, then source 1; repeated next time → source 1 granted first.
- Same address: r9 from both sources captured at the same edge (req0=1, req1=2) → r9 written 2 then 1; final r9=1.
- Address zero: req1 writes r0=0xFF → accepted, `rf_write_enable` never asserted, `pending`=0.
- Reset mid-flight: assert `reset_n`=0 while both slots are held → no further writes, register file contents unchanged, `pending`=0 immediately.
